act_fun_scheduler: RTL and testbench

Sequencer that shares one fixed-point tanh activation unit among the NUM_INPUTS pre-activation values of a neuron layer. On START it captures the whole layer vector and issues one operand at a time to the activation unit. It holds each operand stable until the unit's result returns, then writes the result into an output register bank. It pulses DONE when the batch completes, or aborts with ERROR if the unit fails to answer within a timeout.

---
 rtl/act_fun_scheduler.sv | 175 +++++++++++++++++
 tb/tb_act_fun_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/act_fun_scheduler.sv
// act_fun_scheduler
// Shares one fixed-point tanh unit across the NUM_INPUTS pre-activation values of a layer.
// A START in IDLE captures the whole input vector; operands are then issued one at a time,
// each held stable until its result strobe returns, and the results land in an output bank.
// DONE pulses at batch end; ERROR flags a batch aborted by an activation timeout.
//
// Ports:
//   CLK, RSTN          clock (rising edge), synchronous active-low reset
//   START              begin a batch (IDLE only)
//   VALUES_IN          packed input vector, element i at [i*WIDTH +: WIDTH]
//   VALUES_OUT         packed activated results, same packing
//   BUSY               state != IDLE
//   DONE               one-cycle end-of-batch pulse (normal or aborted)
//   ERROR              sticky timeout flag, cleared by the next accepted START
//   ACT_VALUE_OUT      operand to the activation unit
//   ACT_VALID_OUT      one-cycle issue strobe to the activation unit
//   ACT_VALUE_IN       result from the activation unit
//   ACT_VALID_IN       result strobe from the activation unit
module act_fun_scheduler #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned FRAC_BITS      = 13,
    parameter int unsigned NUM_INPUTS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        START,
    input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
    output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERROR,
    output logic [WIDTH-1:0]            ACT_VALUE_OUT,
    output logic                        ACT_VALID_OUT,
    input  logic [WIDTH-1:0]            ACT_VALUE_IN,
    input  logic                        ACT_VALID_IN
);

    localparam int unsigned IdxW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    // Values are passed through untouched; FRAC_BITS only has to describe a legal format.
    if (NUM_INPUTS < 1 || TIMEOUT_CYCLES < 1 || FRAC_BITS > WIDTH) begin : g_param_check
        $error("act_fun_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  opnd_q [NUM_INPUTS];
    logic [WIDTH-1:0]  opnd_d [NUM_INPUTS];
    logic [WIDTH-1:0]  res_q  [NUM_INPUTS];
    logic [WIDTH-1:0]  res_d  [NUM_INPUTS];
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  act_value_q, act_value_d;
    logic              act_valid_q, act_valid_d;

    logic last_elem;
    logic timed_out;

    assign last_elem = (idx_q == IdxW'(NUM_INPUTS - 1));
    assign timed_out = (cnt_q == CntW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a result strobe takes priority over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (START) state_d = StIssue;
            StIssue:  state_d = StWait;
            StWait: begin
                if (ACT_VALID_IN) begin
                    state_d = last_elem ? StFinish : StIssue;
                end else if (timed_out) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output / datapath next-state; every output is registered, so strobes are
    // computed from the state being entered rather than the current one.
    always_comb begin
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        res_d       = res_q;
        err_d       = err_q;
        act_value_d = act_value_q;
        act_valid_d = (state_d == StIssue);
        done_d      = (state_d == StFinish);

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                        opnd_d[i] = VALUES_IN[i*WIDTH +: WIDTH];
                        res_d[i]  = '0;
                    end
                    err_d       = 1'b0;
                    idx_d       = '0;
                    // Bank is being loaded this same edge, so take element 0 from the input
                    act_value_d = VALUES_IN[WIDTH-1:0];
                end
            end
            StIssue: begin
                cnt_d = '0;
            end
            StWait: begin
                if (ACT_VALID_IN) begin
                    res_d[idx_q] = ACT_VALUE_IN;
                    if (!last_elem) begin
                        idx_d       = idx_q + IdxW'(1);
                        act_value_d = opnd_q[idx_d];
                    end
                end else if (timed_out) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StFinish: ;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            act_value_q <= '0;
            act_valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                opnd_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
            act_value_q <= act_value_d;
            act_valid_q <= act_valid_d;
            opnd_q      <= opnd_d;
            res_q       <= res_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_INPUTS); g++) begin : g_pack
        assign VALUES_OUT[g*WIDTH +: WIDTH] = res_q[g];
    end

    assign BUSY          = (state_q != StIdle);
    assign DONE          = done_q;
    assign ERROR         = err_q;
    assign ACT_VALUE_OUT = act_value_q;
    assign ACT_VALID_OUT = act_valid_q;

endmodule

// File: tb/tb_act_fun_scheduler.sv
// Directed bench for act_fun_scheduler with a small behavioural activation unit that
// returns operand+1 after a per-element latency (0 = never answers).
module tb_act_fun_scheduler;

    localparam int W = 16;
    localparam int N = 4;
    localparam int T = 15;

    logic           CLK = 1'b0;
    logic           RSTN = 1'b0;
    logic           START = 1'b0;
    logic [N*W-1:0] VALUES_IN = '0;
    logic [N*W-1:0] VALUES_OUT;
    logic           BUSY;
    logic           DONE;
    logic           ERROR;
    logic [W-1:0]   ACT_VALUE_OUT;
    logic           ACT_VALID_OUT;
    logic [W-1:0]   ACT_VALUE_IN = '0;
    logic           ACT_VALID_IN = 1'b0;

    act_fun_scheduler #(
        .WIDTH          (W),
        .FRAC_BITS      (13),
        .NUM_INPUTS     (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .START         (START),
        .VALUES_IN     (VALUES_IN),
        .VALUES_OUT    (VALUES_OUT),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERROR         (ERROR),
        .ACT_VALUE_OUT (ACT_VALUE_OUT),
        .ACT_VALID_OUT (ACT_VALID_OUT),
        .ACT_VALUE_IN  (ACT_VALUE_IN),
        .ACT_VALID_IN  (ACT_VALID_IN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Per-batch observations
    int iss [8];
    int n_iss;
    int done_cnt;
    int done_cyc;
    int busy_first;
    int busy_last;
    int stab_bad;

    localparam logic [63:0] NomIn  = 64'h4000_E000_2000_0000;
    localparam logic [63:0] NomOut = 64'h4001_E001_2001_0001;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // START is sampled at the first edge inside the loop (edge 0); iteration k observes
    // and drives cycle k. rst_cyc > 0 drops RSTN for cycle rst_cyc only.
    task automatic run_batch(input logic [63:0] vin, input int lat [4], input bit abuse,
                             input int rst_cyc, input int max_cyc);
        int         reply_cyc;
        logic [W-1:0] op;
        bit         pending;
        bit         rst_seen;
        n_iss = 0; done_cnt = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; stab_bad = 0;
        reply_cyc = -1; op = '0; pending = 1'b0; rst_seen = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1; VALUES_IN = vin; ACT_VALID_IN = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge CLK); #1;
            START        = abuse && (k == 2 || k == 10);
            RSTN         = !(k == rst_cyc);
            ACT_VALID_IN = 1'b0;
            ACT_VALUE_IN = W'($urandom);
            if (rst_cyc > 0 && k > rst_cyc) rst_seen = 1'b1;
            if (BUSY) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (DONE) begin
                done_cnt++;
                done_cyc = k;
            end
            if (pending && !rst_seen && ACT_VALUE_OUT !== op) stab_bad++;
            if (ACT_VALID_OUT) begin
                if (n_iss < 8) iss[n_iss] = k;
                op        = ACT_VALUE_OUT;
                reply_cyc = (n_iss < 4 && lat[n_iss] > 0) ? k + lat[n_iss] : -1;
                n_iss++;
                pending   = 1'b1;
                if (abuse) begin
                    ACT_VALID_IN = 1'b1;
                    ACT_VALUE_IN = 16'hBAD0;
                end
            end
            if (k == reply_cyc) begin
                ACT_VALID_IN = 1'b1;
                ACT_VALUE_IN = op + 16'd1;
                pending      = 1'b0;
            end
        end
        START = 1'b0; ACT_VALID_IN = 1'b0; RSTN = 1'b1;
    endtask

    task automatic check_nominal(input string tag, input logic [63:0] vout);
        check({tag, ".n_issue"}, 64'(n_iss), 64'd4);
        check({tag, ".issue0"}, 64'(iss[0]), 64'd1);
        check({tag, ".issue1"}, 64'(iss[1]), 64'd5);
        check({tag, ".issue2"}, 64'(iss[2]), 64'd9);
        check({tag, ".issue3"}, 64'(iss[3]), 64'd13);
        check({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, ".done_cyc"}, 64'(done_cyc), 64'd17);
        check({tag, ".busy_first"}, 64'(busy_first), 64'd1);
        check({tag, ".busy_last"}, 64'(busy_last), 64'd17);
        check({tag, ".stable"}, 64'(stab_bad), 64'd0);
        check({tag, ".values"}, VALUES_OUT, vout);
        check({tag, ".error"}, 64'(ERROR), 64'd0);
    endtask

    initial begin
        // Reset with random inputs and START asserted
        for (int i = 0; i < 3; i++) begin
            RSTN = 1'b0; START = 1'b1;
            VALUES_IN    = {$urandom, $urandom};
            ACT_VALUE_IN = W'($urandom);
            ACT_VALID_IN = 1'($urandom);
            @(posedge CLK); #1;
        end
        check("rst.values", VALUES_OUT, 64'd0);
        check("rst.busy", 64'(BUSY), 64'd0);
        check("rst.done", 64'(DONE), 64'd0);
        check("rst.error", 64'(ERROR), 64'd0);
        check("rst.act_value", 64'(ACT_VALUE_OUT), 64'd0);
        check("rst.act_valid", 64'(ACT_VALID_OUT), 64'd0);
        RSTN = 1'b1; START = 1'b0; ACT_VALID_IN = 1'b0;
        @(posedge CLK); #1;
        check("rst.busy_after", 64'(BUSY), 64'd0);
        check("rst.valid_after", 64'(ACT_VALID_OUT), 64'd0);

        // Nominal batch, L=3
        run_batch(NomIn, '{3, 3, 3, 3}, 1'b0, 0, 25);
        check_nominal("nom", NomOut);

        // Result strobe while idle must not touch the results
        ACT_VALID_IN = 1'b1; ACT_VALUE_IN = 16'h1234;
        @(posedge CLK); #1;
        ACT_VALID_IN = 1'b0;
        @(posedge CLK); #1;
        check("idle_strobe.values", VALUES_OUT, NomOut);
        check("idle_strobe.busy", 64'(BUSY), 64'd0);

        // Variable latency 1,7,1,7: issues 1,3,11,13; last result in 20, DONE in 21
        run_batch(64'h1111_2222_3333_7FFF, '{1, 7, 1, 7}, 1'b0, 0, 30);
        check("var.n_issue", 64'(n_iss), 64'd4);
        check("var.issue0", 64'(iss[0]), 64'd1);
        check("var.issue1", 64'(iss[1]), 64'd3);
        check("var.issue2", 64'(iss[2]), 64'd11);
        check("var.issue3", 64'(iss[3]), 64'd13);
        check("var.done_cnt", 64'(done_cnt), 64'd1);
        check("var.done_cyc", 64'(done_cyc), 64'd21);
        check("var.stable", 64'(stab_bad), 64'd0);
        check("var.values", VALUES_OUT, 64'h1112_2223_3334_8000);

        // Protocol abuse: stray START in cycles 2/10, stray strobe in every ISSUE cycle
        run_batch(NomIn, '{3, 3, 3, 3}, 1'b1, 0, 25);
        check_nominal("abuse", NomOut);

        // Timeout on element 2 (issued in cycle 9): DONE in 9+15+2 = 26
        run_batch(NomIn, '{3, 3, 0, 3}, 1'b0, 0, 40);
        check("tmo.n_issue", 64'(n_iss), 64'd3);
        check("tmo.done_cnt", 64'(done_cnt), 64'd1);
        check("tmo.done_cyc", 64'(done_cyc), 64'd26);
        check("tmo.busy_last", 64'(busy_last), 64'd26);
        check("tmo.error", 64'(ERROR), 64'd1);
        check("tmo.values", VALUES_OUT, 64'h0000_0000_2001_0001);

        // Next START clears ERROR and runs normally
        run_batch(NomIn, '{3, 3, 3, 3}, 1'b0, 0, 25);
        check_nominal("post_tmo", NomOut);

        // Reset in cycle 6; the element-1 result strobe in cycle 8 arrives after reset
        run_batch(NomIn, '{3, 3, 3, 3}, 1'b0, 6, 20);
        check("mid_rst.n_issue", 64'(n_iss), 64'd2);
        check("mid_rst.done_cnt", 64'(done_cnt), 64'd0);
        check("mid_rst.busy_last", 64'(busy_last), 64'd6);
        check("mid_rst.values", VALUES_OUT, 64'd0);
        check("mid_rst.error", 64'(ERROR), 64'd0);
        check("mid_rst.act_value", 64'(ACT_VALUE_OUT), 64'd0);
        check("mid_rst.busy", 64'(BUSY), 64'd0);

        run_batch(NomIn, '{3, 3, 3, 3}, 1'b0, 0, 25);
        check_nominal("post_rst", NomOut);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
